// File: rtl/button_conditioner.sv
// Purpose : per-channel 2-flop synchroniser, consecutive-sample debounce and sticky edge flags.
// Latency : a raw change shows on level/rise/fall DEBOUNCE_CYCLES+2 rising edges later.
// Backpr. : none; this is a free-running conditioner and every output is a plain register.
// Ports   : clk, rst (async, active-high); raw[WIDTH], clr[WIDTH] in;
//           level, rise, fall, seen_rise, seen_fall [WIDTH] out.
module button_conditioner #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] seen_rise,
  output logic [WIDTH-1:0] seen_fall
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0]         s1_q, s1_d;
  logic [WIDTH-1:0]         s2_q, s2_d;
  logic [WIDTH-1:0]         level_q, level_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;
  logic [WIDTH-1:0]         seen_rise_q, seen_rise_d;
  logic [WIDTH-1:0]         seen_fall_q, seen_fall_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    // STABLE/PENDING is implicit: a channel is PENDING whenever s2 differs
    // from the accepted level, and cnt tracks how long it has differed.
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    // A new event on the same edge as clr keeps the flag set.
    seen_rise_d = (seen_rise_q & ~clr) | rise_d;
    seen_fall_d = (seen_fall_q & ~clr) | fall_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      level_q     <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      seen_rise_q <= '0;
      seen_fall_q <= '0;
      cnt_q       <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      seen_rise_q <= seen_rise_d;
      seen_fall_q <= seen_fall_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign seen_rise = seen_rise_q;
  assign seen_fall = seen_fall_q;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] raw, clr;
  logic [1:0] level, rise, fall, seen_rise, seen_fall;
  logic [0:0] raw1, clr1;
  logic [0:0] level1, rise1, fall1, seen_rise1, seen_fall1;

  int errors = 0;
  int checks = 0;

  button_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .raw(raw), .clr(clr),
    .level(level), .rise(rise), .fall(fall),
    .seen_rise(seen_rise), .seen_fall(seen_fall)
  );

  button_conditioner #(.WIDTH(1), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .raw(raw1), .clr(clr1),
    .level(level1), .rise(rise1), .fall(fall1),
    .seen_rise(seen_rise1), .seen_fall(seen_fall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({level, rise, fall, seen_rise, seen_fall} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {level, rise, fall, seen_rise, seen_fall});
    end
    rst = 1'b0;
  endtask

  task automatic test_glitch();
    logic [1:0] any_pulse = 2'b00;
    logic [1:0] any_level = 2'b00;
    raw = 2'b01;
    for (int t = 0; t < 13; t++) begin
      if (t == 3) raw = 2'b00;
      tick();
      any_pulse |= rise | fall;
      any_level |= level;
    end
    checks++;
    if (any_pulse !== 2'b00) begin
      errors++;
      $display("FAIL glitch_pulses: got %b expected 00", any_pulse);
    end
    checks++;
    if (any_level !== 2'b00) begin
      errors++;
      $display("FAIL glitch_level: got %b expected 00", any_level);
    end
  endtask

  task automatic test_clean_rise();
    raw = 2'b01;
    for (int t = 0; t < 5; t++) tick();
    checks++;
    if ({level, rise} !== 4'b0000) begin
      errors++;
      $display("FAIL rise_early: got level/rise %b expected 0000", {level, rise});
    end
    tick();
    checks++;
    if ({level, rise, fall, seen_rise} !== 8'b01_01_00_01) begin
      errors++;
      $display("FAIL rise_edge5: got level/rise/fall/seen_rise %b expected 01010001", {level, rise, fall, seen_rise});
    end
    tick();
    checks++;
    if ({level, rise, seen_rise} !== 6'b01_00_01) begin
      errors++;
      $display("FAIL rise_edge6: got level/rise/seen_rise %b expected 010001", {level, rise, seen_rise});
    end
    for (int t = 0; t < 3; t++) tick();
    checks++;
    if ({level, seen_rise, seen_fall} !== 6'b01_01_00) begin
      errors++;
      $display("FAIL rise_sticky: got level/seen_rise/seen_fall %b expected 010100", {level, seen_rise, seen_fall});
    end
  endtask

  task automatic test_bounce();
    int rise_cnt = 0;
    int fall_cnt = 0;
    int rise_at  = -1;
    for (int t = 0; t < 20; t++) begin
      raw[1] = (t < 6) ? ((t % 2) == 0) : 1'b1;
      tick();
      if (rise[1]) begin
        rise_cnt++;
        rise_at = t;
      end
      if (fall[1]) fall_cnt++;
    end
    checks++;
    if (rise_cnt != 1) begin
      errors++;
      $display("FAIL bounce_rise_count: got %0d expected 1", rise_cnt);
    end
    checks++;
    if (rise_at != 11) begin
      errors++;
      $display("FAIL bounce_rise_edge: got %0d expected 11", rise_at);
    end
    checks++;
    if (fall_cnt != 0) begin
      errors++;
      $display("FAIL bounce_fall_count: got %0d expected 0", fall_cnt);
    end
    checks++;
    if ({level, seen_rise} !== 4'b11_11) begin
      errors++;
      $display("FAIL bounce_level: got level/seen_rise %b expected 1111", {level, seen_rise});
    end
  endtask

  task automatic test_fall_clr();
    raw = 2'b10;
    for (int t = 0; t < 5; t++) tick();
    checks++;
    if ({level, fall} !== 4'b11_00) begin
      errors++;
      $display("FAIL fall_early: got level/fall %b expected 1100", {level, fall});
    end
    clr = 2'b01;
    tick();
    checks++;
    if ({level, fall, seen_fall, seen_rise} !== 8'b10_01_01_10) begin
      errors++;
      $display("FAIL fall_clr_collide: got level/fall/seen_fall/seen_rise %b expected 10010110", {level, fall, seen_fall, seen_rise});
    end
    tick();
    checks++;
    if ({fall, seen_fall, seen_rise} !== 6'b00_00_10) begin
      errors++;
      $display("FAIL clr_alone: got fall/seen_fall/seen_rise %b expected 000010", {fall, seen_fall, seen_rise});
    end
    clr = 2'b00;
  endtask

  task automatic test_reset_mid();
    raw = 2'b11;
    for (int t = 0; t < 3; t++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({level, rise, fall, seen_rise, seen_fall} !== 10'b0) begin
      errors++;
      $display("FAIL reset_async: got %b expected 0", {level, rise, fall, seen_rise, seen_fall});
    end
    tick();
    tick();
    checks++;
    if ({level, rise, fall, seen_rise, seen_fall} !== 10'b0) begin
      errors++;
      $display("FAIL reset_held: got %b expected 0", {level, rise, fall, seen_rise, seen_fall});
    end
    rst = 1'b0;
    for (int t = 0; t < 5; t++) tick();
    checks++;
    if ({level, rise} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_early: got level/rise %b expected 0000", {level, rise});
    end
    tick();
    checks++;
    if ({level, rise, fall, seen_rise} !== 8'b11_11_00_11) begin
      errors++;
      $display("FAIL post_reset_rise: got level/rise/fall/seen_rise %b expected 11110011", {level, rise, fall, seen_rise});
    end
    tick();
    checks++;
    if ({rise, seen_rise} !== 4'b00_11) begin
      errors++;
      $display("FAIL post_reset_once: got rise/seen_rise %b expected 0011", {rise, seen_rise});
    end
  endtask

  task automatic test_parallel_fall();
    raw = 2'b01;
    for (int t = 0; t < 5; t++) tick();
    checks++;
    if ({level, fall} !== 4'b11_00) begin
      errors++;
      $display("FAIL par_fall_early: got level/fall %b expected 1100", {level, fall});
    end
    tick();
    checks++;
    if ({level, rise, fall, seen_fall} !== 8'b01_00_10_10) begin
      errors++;
      $display("FAIL par_fall: got level/rise/fall/seen_fall %b expected 01001010", {level, rise, fall, seen_fall});
    end
  endtask

  task automatic test_d1();
    raw1 = 1'b1;
    tick();
    tick();
    checks++;
    if ({level1, rise1} !== 2'b00) begin
      errors++;
      $display("FAIL d1_early: got level/rise %b expected 00", {level1, rise1});
    end
    tick();
    checks++;
    if ({level1, rise1, seen_rise1} !== 3'b111) begin
      errors++;
      $display("FAIL d1_edge2: got level/rise/seen_rise %b expected 111", {level1, rise1, seen_rise1});
    end
    tick();
    checks++;
    if ({level1, rise1} !== 2'b10) begin
      errors++;
      $display("FAIL d1_pulse_end: got level/rise %b expected 10", {level1, rise1});
    end
  endtask

  initial begin
    rst  = 1'b1;
    raw  = 2'b00;
    clr  = 2'b00;
    raw1 = 1'b0;
    clr1 = 1'b0;
    test_reset();
    test_glitch();
    test_clean_rise();
    test_bounce();
    test_fall_clr();
    test_reset_mid();
    test_parallel_fall();
    test_d1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel input conditioner placed directly upstream of the lab's gate-level primitive stages (OR/AND/NOT networks). It takes raw, asynchronous, bouncing switch/button lines and delivers clean, synchronous levels plus single-cycle edge pulses. Each channel gets a two-flop synchroniser, a consecutive-sample debounce counter and sticky event flags. The primitive gates downstream therefore never see metastable or bouncing inputs.

## Interface
- WIDTH, 2, number of independent input channels (≥1)
- DEBOUNCE_CYCLES, 4, consecutive differing synchronised samples needed to accept a new level (≥1; synthesis builds use board-scale values, simulation uses 4)
- CW, derived = clog2(DEBOUNCE_CYCLES+1), counter width per channel

- clk  in  1  single system clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- raw  in  WIDTH  unsynchronised switch/button inputs
- clr  in  WIDTH  synchronous per-channel clear of sticky flags
- level  out  WIDTH  debounced, registered level (feeds gate inputs a, b)
- rise  out  WIDTH  one-cycle pulse when level goes 0→1
- fall  out  WIDTH  one-cycle pulse when level goes 1→0
- seen_rise  out  WIDTH  sticky: a rise occurred since last clr/reset
- seen_fall  out  WIDTH  sticky: a fall occurred since last clr/reset

## Operation
- Per channel i, all logic independent; no cross-channel interaction.
- Sync: s1[i] <= raw[i]; s2[i] <= s1[i]. Only s2 is used downstream.
- Debounce: two states per channel, STABLE (s2 == level) and PENDING (s2 != level, cnt counting).
  - s2 == level: cnt <= 0 (PENDING aborts back to STABLE, no output change).
  - s2 != level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != level and cnt == DEBOUNCE_CYCLES-1: level <= s2, cnt <= 0, assert rise (s2=1) or fall (s2=0) for exactly that cycle.
- cnt never exceeds DEBOUNCE_CYCLES-1 and does not wrap.
- rise/fall are registered and mutually exclusive per channel. They are 0 in every cycle without an accepted transition.
- Sticky flags: seen_rise[i] <= 1 on the cycle rise[i] is asserted, cleared by clr[i]. If clr[i] and a new rise[i] coincide, set wins (flag stays 1). Same rule for seen_fall.
- Reset (any time, including mid-PENDING): s1, s2, cnt, level, rise, fall, seen_rise, seen_fall all go to 0 immediately. After release, a raw input held at 1 is accepted as a normal rise.

## Timing
- Reset values: every output is 0.
- Latency: raw change captured at edge E0 (into s1). s2 follows at E1. Counting edges are E2..E(1+D), where D = DEBOUNCE_CYCLES. level, rise and fall update at edge E(1+D), so the total latency is D+2 rising edges after the raw change.
- A raw pulse or glitch whose synchronised width is shorter than D cycles produces no level change and no pulses.
- D=1: level follows s2 one cycle later, giving a latency of 3 edges.
- The minimum spacing between successive accepted transitions on one channel is D cycles.
- Outputs are glitch-free registers and are safe to feed combinational gates with #3 delays in the same clock period.

## Test plan
- Reset: assert rst mid-simulation with raw=2'b11 and one channel in PENDING -> all outputs read 0 asynchronously, before the next clk edge. After release, each channel shows rise exactly once, D+2 edges later.
- Clean rise, D=4: raw[0] 0→1 before edge 0 -> level[0]=1 and rise[0]=1 after edge 5. rise[0]=0 after edge 6. seen_rise[0]=1 and stays 1. Channel 1 unaffected.
- Bounce: raw[1] toggles 1,0,1,0 each cycle for 6 cycles, then holds 1 -> no rise until 4 consecutive stable synchronised samples, then exactly one rise[1] pulse. fall[1] is never asserted.
- Glitch reject: raw[0]=1 for 3 cycles, then back to 0 -> level[0] stays 0 and no pulses occur.
- Fall with clr collision: level[0]=1; drop raw[0] and assert clr[0] on the same cycle fall[0] fires -> seen_fall[0]=1. clr[0] alone one cycle later -> seen_fall[0]=0.
- Parallel channels: raw=2'b11 simultaneously -> rise=2'b11 on the same cycle. Then raw=2'b01 -> fall=2'b10 only, D+2 edges later.
